// File: rtl/mic_b_bus_mux.sv
// Registered B-bus source selector: valid/ready select in, one-hot enable plus captured word out.
// Optional MBR/MBRU byte sources are enabled by defining MIC_MBR_EXT_EN.
//
// state    | meaning
// IDLE     | nothing driven, ready for a selection
// DRIVE    | b_bus/b_en valid for exactly one cycle, still accepting
// WAIT_MDR | MDR selected while a memory read is filling it; stalled
module mic_b_bus_mux #(
  parameter int WIDTH    = 32,
  parameter int NUM_SRC  = 8,
  parameter int MDR_IDX  = 7,
  parameter int WAIT_MAX = 15,
`ifdef MIC_MBR_EXT_EN
  localparam int NSEL    = NUM_SRC + 2,
`else
  localparam int NSEL    = NUM_SRC,
`endif
  localparam int SEL_W   = (NSEL > 1) ? $clog2(NSEL) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  output logic                     sel_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     mdr_busy,
  input  logic [7:0]               mbr_byte,
  output logic                     b_valid,
  output logic [NSEL-1:0]          b_en,
  output logic [WIDTH-1:0]         b_bus,
  output logic                     err_sel,
  output logic                     err_timeout
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DRIVE    = 2'd1;
  localparam logic [1:0] ST_WAIT_MDR = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             b_valid_q, b_valid_d;
  logic [NSEL-1:0]  b_en_q, b_en_d;
  logic [WIDTH-1:0] b_bus_q, b_bus_d;
  logic             err_sel_q, err_sel_d;
  logic             err_timeout_q, err_timeout_d;

  logic             accept;
  logic             sel_illegal;
  logic             sel_is_mdr;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] mdr_word;

  assign sel_ready   = (state_q != ST_WAIT_MDR);
  assign accept      = sel_valid && sel_ready;
  assign sel_illegal = ({1'b0, sel} >= (SEL_W+1)'(NSEL));
  assign sel_is_mdr  = (sel == SEL_W'(MDR_IDX));
  assign mdr_word    = src_data[MDR_IDX*WIDTH +: WIDTH];

  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (sel == SEL_W'(i)) sel_word = src_data[i*WIDTH +: WIDTH];
    end
`ifdef MIC_MBR_EXT_EN
    if (sel == SEL_W'(NUM_SRC))     sel_word = {{(WIDTH-8){mbr_byte[7]}}, mbr_byte};
    if (sel == SEL_W'(NUM_SRC + 1)) sel_word = {{(WIDTH-8){1'b0}}, mbr_byte};
`endif
  end

`ifndef MIC_MBR_EXT_EN
  logic unused_mbr;
  assign unused_mbr = ^mbr_byte;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    b_valid_d     = 1'b0;
    b_en_d        = '0;
    b_bus_d       = b_bus_q;
    err_sel_d     = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      ST_WAIT_MDR: begin
        if (!mdr_busy) begin
          state_d   = ST_DRIVE;
          cnt_d     = '0;
          b_valid_d = 1'b1;
          b_en_d    = NSEL'(1) << MDR_IDX;
          b_bus_d   = mdr_word;
        end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
          state_d       = ST_IDLE;
          cnt_d         = '0;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        // IDLE and DRIVE behave alike: a drive never outlives its one cycle
        state_d = ST_IDLE;
        if (accept) begin
          if (sel_illegal) begin
            err_sel_d = 1'b1;
          end else if (sel_is_mdr && mdr_busy) begin
            state_d = ST_WAIT_MDR;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d   = ST_DRIVE;
            b_valid_d = 1'b1;
            b_en_d    = NSEL'(1) << sel;
            b_bus_d   = sel_word;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      b_valid_q     <= 1'b0;
      b_en_q        <= '0;
      b_bus_q       <= '0;
      err_sel_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      b_valid_q     <= b_valid_d;
      b_en_q        <= b_en_d;
      b_bus_q       <= b_bus_d;
      err_sel_q     <= err_sel_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign b_valid     = b_valid_q;
  assign b_en        = b_en_q;
  assign b_bus       = b_bus_q;
  assign err_sel     = err_sel_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_mic_b_bus_mux.sv
// Self-checking bench for mic_b_bus_mux: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mic_b_bus_mux;

  localparam int WIDTH    = 32;
  localparam int NUM_SRC  = 8;
  localparam int MDR_IDX  = 7;
  localparam int WAIT_MAX = 15;
`ifdef MIC_MBR_EXT_EN
  localparam int NSEL = NUM_SRC + 2;
`else
  localparam int NSEL = NUM_SRC;
`endif
  localparam int SEL_W = $clog2(NSEL);

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     sel_valid = 1'b0;
  logic                     sel_ready;
  logic [SEL_W-1:0]         sel = '0;
  logic [NUM_SRC*WIDTH-1:0] src_data = '0;
  logic                     mdr_busy = 1'b0;
  logic [7:0]               mbr_byte = 8'h00;
  logic                     b_valid;
  logic [NSEL-1:0]          b_en;
  logic [WIDTH-1:0]         b_bus;
  logic                     err_sel;
  logic                     err_timeout;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit              m_ready;
  int              m_waited;
  bit              m_valid;
  logic [NSEL-1:0] m_en;
  logic [WIDTH-1:0] m_bus;
  bit              m_err_sel;
  bit              m_err_to;

  always #5 clk = ~clk;

  mic_b_bus_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .MDR_IDX(MDR_IDX), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_ready(sel_ready), .sel(sel),
    .src_data(src_data), .mdr_busy(mdr_busy), .mbr_byte(mbr_byte), .b_valid(b_valid),
    .b_en(b_en), .b_bus(b_bus), .err_sel(err_sel), .err_timeout(err_timeout)
  );

`ifndef MIC_MBR_EXT_EN
  logic           v6 = 1'b0;
  logic           r6;
  logic [2:0]     s6 = '0;
  logic [191:0]   src6 = '0;
  logic           busy6 = 1'b0;
  logic [7:0]     mbr6 = 8'h00;
  logic           bv6;
  logic [5:0]     en6;
  logic [31:0]    bus6;
  logic           es6;
  logic           et6;

  mic_b_bus_mux #(.WIDTH(32), .NUM_SRC(6), .MDR_IDX(5), .WAIT_MAX(WAIT_MAX)) dut6 (
    .clk(clk), .rst_n(rst_n), .sel_valid(v6), .sel_ready(r6), .sel(s6),
    .src_data(src6), .mdr_busy(busy6), .mbr_byte(mbr6), .b_valid(bv6),
    .b_en(en6), .b_bus(bus6), .err_sel(es6), .err_timeout(et6)
  );
`endif

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_word(input int s);
    logic [WIDTH-1:0] w;
    w = '0;
    if (s < NUM_SRC) w = src_data[s*WIDTH +: WIDTH];
`ifdef MIC_MBR_EXT_EN
    if (s == NUM_SRC) begin
      w = WIDTH'(mbr_byte);
      if (mbr_byte[7]) w = w - WIDTH'(256);
    end
    if (s == NUM_SRC + 1) w = WIDTH'(mbr_byte);
`endif
    return w;
  endfunction

  task automatic m_reset();
    m_ready = 1'b1; m_waited = 0; m_valid = 1'b0; m_en = '0;
    m_bus = '0; m_err_sel = 1'b0; m_err_to = 1'b0;
  endtask

  task automatic m_drive(input int s);
    m_valid = 1'b1;
    m_en = '0;
    m_en[s] = 1'b1;
    m_bus = ref_word(s);
  endtask

  // Predicts the next cycle's outputs from the inputs presented this cycle.
  task automatic model_step();
    int s;
    s = int'(sel);
    m_valid = 1'b0; m_en = '0; m_err_sel = 1'b0; m_err_to = 1'b0;
    if (!m_ready) begin
      if (!mdr_busy) begin
        m_ready = 1'b1;
        m_drive(MDR_IDX);
      end else if (m_waited >= WAIT_MAX) begin
        m_ready = 1'b1;
        m_err_to = 1'b1;
      end else begin
        m_waited++;
      end
    end else if (sel_valid) begin
      if (s >= NSEL) m_err_sel = 1'b1;
      else if (s == MDR_IDX && mdr_busy) begin
        m_ready = 1'b0;
        m_waited = 1;
      end else m_drive(s);
    end
  endtask

  task automatic compare_all();
    chk_eq("b_valid", b_valid, m_valid);
    chk_eq("b_en", b_en, m_en);
    chk_eq("b_bus", b_bus, m_bus);
    chk_eq("err_sel", err_sel, m_err_sel);
    chk_eq("err_timeout", err_timeout, m_err_to);
    chk_eq("sel_ready", sel_ready, m_ready);
  endtask

  task automatic tick(input bit v, input int s, input bit busy);
    sel_valid = v;
    sel = SEL_W'(s);
    mdr_busy = busy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_src(input int idx, input logic [WIDTH-1:0] w);
    src_data[idx*WIDTH +: WIDTH] = w;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk_eq({tag, "_valid"}, b_valid, 0);
    chk_eq({tag, "_en"}, b_en, 0);
    chk_eq({tag, "_bus"}, b_bus, 0);
    chk_eq({tag, "_errs"}, {err_sel, err_timeout}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int vseen;
    m_reset();
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("ready_after_reset", sel_ready, 1);

    set_src(0, 32'h0000_1234);
    tick(1, 0, 0);
    chk_eq("h_valid", b_valid, 1);
    chk_eq("h_en", b_en, 'h01);
    chk_eq("h_bus", b_bus, 32'h0000_1234);
    tick(0, 0, 0);
    chk_eq("h_idle_valid", b_valid, 0);

    set_src(6, 32'hA);
    set_src(5, 32'hB);
    tick(1, 6, 0);
    chk_eq("b2b_en0", b_en, 'h40);
    chk_eq("b2b_bus0", b_bus, 32'hA);
    tick(1, 5, 0);
    chk_eq("b2b_valid1", b_valid, 1);
    chk_eq("b2b_en1", b_en, 'h20);
    chk_eq("b2b_bus1", b_bus, 32'hB);
    tick(0, 0, 0);

    set_src(7, 32'hDEAD_BEEF);
    tick(1, 7, 1);
    chk_eq("mdr_ready0", sel_ready, 0);
    tick(0, 0, 1);
    chk_eq("mdr_ready1", sel_ready, 0);
    tick(0, 0, 1);
    chk_eq("mdr_ready2", sel_ready, 0);
    tick(0, 0, 0);
    chk_eq("mdr_valid", b_valid, 1);
    chk_eq("mdr_en", b_en, 'h80);
    chk_eq("mdr_bus", b_bus, 32'hDEAD_BEEF);
    tick(0, 0, 0);

    tick(1, 7, 1);
    pulses = 0;
    vseen = 0;
    for (int i = 0; i < WAIT_MAX + 5; i++) begin
      tick(0, 0, 1);
      pulses += int'(err_timeout);
      vseen  += int'(b_valid);
    end
    chk_eq("timeout_pulses", pulses, 1);
    chk_eq("timeout_no_valid", vseen, 0);
    chk_eq("timeout_ready", sel_ready, 1);

    tick(1, 7, 1);
    chk_eq("pre_reset_ready", sel_ready, 0);
    sel_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_reset");
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mdr_busy = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_mid_reset", sel_ready, 1);
    tick(0, 0, 0);

`ifndef MIC_MBR_EXT_EN
    v6 = 1'b1;
    s6 = 3'd7;
    @(posedge clk);
    @(negedge clk);
    v6 = 1'b0;
    chk_eq("ill_err_sel", es6, 1);
    chk_eq("ill_valid", bv6, 0);
    chk_eq("ill_en", en6, 0);
    chk_eq("ill_bus", bus6, 0);
    @(posedge clk);
    @(negedge clk);
    chk_eq("ill_err_sel_clear", es6, 0);
    chk_eq("ill_ready", r6, 1);
`else
    mbr_byte = 8'h80;
    tick(1, NUM_SRC, 0);
    chk_eq("mbr_bus", b_bus, 32'hFFFF_FF80);
    chk_eq("mbr_en", b_en, 'h100);
    tick(1, NUM_SRC + 1, 0);
    chk_eq("mbru_bus", b_bus, 32'h0000_0080);
    tick(1, NSEL, 0);
    chk_eq("ill_err_sel", err_sel, 1);
    chk_eq("ill_valid", b_valid, 0);
    chk_eq("ill_bus_hold", b_bus, 32'h0000_0080);
    tick(0, 0, 0);
`endif

    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NUM_SRC; k++) set_src(k, WIDTH'($urandom));
      mbr_byte = 8'($urandom);
      tick(($urandom_range(0, 9) < 7), int'($urandom_range(0, (1 << SEL_W) - 1)),
           ((i % 160) < 40) ? 1'b1 : ($urandom_range(0, 2) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
